// File: rtl/axib_sim_mem.sv
// Simulation-side AXI4 slave memory: word-addressed 32-bit store with independent
// write and read burst engines and a programmable first-beat read latency.
module axib_sim_mem #(
    parameter int unsigned WORD_BITS  = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [7:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [7:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    input  logic [7:0]  arid_i,
    input  logic [31:0] araddr_i,
    input  logic [7:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [7:0]  rid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i
);
    localparam int unsigned DEPTH = 1 << WORD_BITS;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    logic [31:0] mem_q [DEPTH];

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> (WORD_BITS + 2)) == 32'd0);
    endfunction

    function automatic logic [WORD_BITS-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE_ADDR) >> 2;
        return off[WORD_BITS-1:0];
    endfunction

    // Only 32-bit FIXED/INCR bursts are served; anything else fails as a whole.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
        return !(burst == BURST_FIXED || burst == BURST_INCR) || (size != 3'd2);
    endfunction

    function automatic logic [31:0] addr_step(input logic [1:0] burst);
        return (burst == BURST_INCR) ? 32'd4 : 32'd0;
    endfunction

    // ---------------- write engine ----------------
    wstate_t     wstate_q, wstate_d;
    logic [7:0]  wid_q, wid_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d;
    logic [1:0]  wburst_q, wburst_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        wbad_q, wbad_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        wr_en;
    logic        wr_ok;

    always_comb begin
        wstate_d  = wstate_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        wbad_d    = wbad_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        wr_ok     = !wbad_q && in_range(waddr_q);
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready_o = 1'b1;
                if (awvalid_i) begin
                    wid_d    = awid_i;
                    waddr_d  = awaddr_i;
                    wlen_d   = awlen_i;
                    wburst_d = awburst_i;
                    wcnt_d   = 8'd0;
                    wbad_d   = burst_bad(awburst_i, awsize_i);
                    bresp_d  = RESP_OKAY;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    wr_en = wr_ok;
                    // The beat count, not wlast, closes the burst; a misplaced wlast only flags it.
                    if (!wr_ok || (wlast_i != (wcnt_q == wlen_q))) begin
                        bresp_d = RESP_SLVERR;
                    end
                    if (wcnt_q == wlen_q) begin
                        wstate_d = W_RESP;
                    end else begin
                        wcnt_d  = wcnt_q + 8'd1;
                        waddr_d = waddr_q + addr_step(wburst_q);
                    end
                end
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q <= W_IDLE;
            wid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wburst_q <= '0;
            wcnt_q   <= '0;
            wbad_q   <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wstate_q <= wstate_d;
            wid_q    <= wid_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wburst_q <= wburst_d;
            wcnt_q   <= wcnt_d;
            wbad_q   <= wbad_d;
            bresp_q  <= bresp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[word_idx(waddr_q)][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign bid_o   = wid_q;
    assign bresp_o = bresp_q;

    // ---------------- read engine ----------------
    rstate_t     rstate_q, rstate_d;
    logic [7:0]  rid_q, rid_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d;
    logic [1:0]  rburst_q, rburst_d;
    logic        rbad_q, rbad_d;
    logic [7:0]  rbeat_q, rbeat_d;
    logic [7:0]  lat_q, lat_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic [31:0] rdata_q;
    logic        rd_fetch;
    logic        fetch_ok;
    logic [31:0] fetch_addr;
    logic [7:0]  fetch_beat;

    always_comb begin
        rstate_d   = rstate_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rburst_d   = rburst_q;
        rbad_d     = rbad_q;
        rbeat_d    = rbeat_q;
        lat_d      = lat_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        rd_fetch   = 1'b0;
        fetch_addr = raddr_q;
        fetch_beat = rbeat_q;
        arready_o  = 1'b0;
        rvalid_o   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready_o = 1'b1;
                if (arvalid_i) begin
                    rid_d    = arid_i;
                    raddr_d  = araddr_i;
                    rlen_d   = arlen_i;
                    rburst_d = arburst_i;
                    rbad_d   = burst_bad(arburst_i, arsize_i);
                    rbeat_d  = 8'd0;
                    lat_d    = 8'(RD_LATENCY - 1);
                    rstate_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (lat_q == 8'd0) begin
                    rd_fetch = 1'b1;
                    rstate_d = R_DATA;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            R_DATA: begin
                rvalid_o = 1'b1;
                if (rready_i) begin
                    if (rlast_q) begin
                        rlast_d  = 1'b0;
                        rstate_d = R_IDLE;
                    end else begin
                        // Fetch the following beat on the accepting edge so beats stream back-to-back.
                        fetch_addr = raddr_q + addr_step(rburst_q);
                        fetch_beat = rbeat_q + 8'd1;
                        raddr_d    = fetch_addr;
                        rbeat_d    = fetch_beat;
                        rd_fetch   = 1'b1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        fetch_ok = !rbad_q && in_range(fetch_addr);
        if (rd_fetch) begin
            rresp_d = fetch_ok ? RESP_OKAY : RESP_SLVERR;
            rlast_d = (fetch_beat == rlen_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rburst_q <= '0;
            rbad_q   <= 1'b0;
            rbeat_q  <= '0;
            lat_q    <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rburst_q <= rburst_d;
            rbad_q   <= rbad_d;
            rbeat_q  <= rbeat_d;
            lat_q    <= lat_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            if (rd_fetch) begin
                rdata_q <= fetch_ok ? mem_q[word_idx(fetch_addr)] : 32'd0;
            end
        end
    end

    assign rid_o   = rid_q;
    assign rdata_o = rdata_q;
    assign rresp_o = rresp_q;
    assign rlast_o = rlast_q;
endmodule
